// File: rtl/exi_master.sv
// EXI/SPI initiator: sends one 16-bit frame per request ({cmd, data, 4'h0}, MSB-first)
// and returns the 16 miso bits captured during the frame.
module exi_master #(
   parameter int CLK_DIV = 8,
   parameter int CS_GAP  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_cmd,
   input  logic [7:0]  req_data,
   output logic        rsp_valid,
   output logic [15:0] rsp_word,
   output logic        busy,
   output logic        sck,
   output logic        cs,
   output logic        mosi,
   input  logic        miso
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int GAP_W = $clog2(CS_GAP + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP);

   // The responder needs time to sync sck and to see cs high between frames.
   generate
      if (CLK_DIV < 8) begin : g_bad_clk_div
         $error("exi_master: CLK_DIV must be >= 8");
      end
      if (CS_GAP < 4) begin : g_bad_cs_gap
         $error("exi_master: CS_GAP must be >= 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LOW,
      HIGH,
      HOLD,
      GAP
   } state_t;

   state_t            state_reg;
   logic [DIV_W-1:0]  div_reg;
   logic [GAP_W-1:0]  gap_reg;
   logic [3:0]        bit_reg;
   logic [15:0]       tx_reg;
   logic [15:0]       rx_reg;
   logic [1:0]        miso_sync_reg;
   logic              cs_reg;
   logic              sck_reg;
   logic              mosi_reg;
   logic              ready_reg;
   logic              busy_reg;
   logic              rsp_valid_reg;
   logic [15:0]       rsp_word_reg;

   logic              div_last;
   logic              miso_synced;

   assign div_last    = (div_reg == DIV_LAST);
   assign miso_synced = miso_sync_reg[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miso_sync_reg <= 2'b00;
      end else begin
         miso_sync_reg <= {miso_sync_reg[0], miso};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         div_reg       <= '0;
         gap_reg       <= '0;
         bit_reg       <= 4'd0;
         tx_reg        <= 16'h0000;
         rx_reg        <= 16'h0000;
         cs_reg        <= 1'b1;
         sck_reg       <= 1'b0;
         mosi_reg      <= 1'b0;
         ready_reg     <= 1'b1;
         busy_reg      <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_word_reg  <= 16'h0000;
      end else begin
         rsp_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req_valid && ready_reg) begin
                  tx_reg    <= {req_cmd, req_data, 4'h0};
                  bit_reg   <= 4'd0;
                  div_reg   <= '0;
                  cs_reg    <= 1'b0;
                  sck_reg   <= 1'b0;
                  mosi_reg  <= req_cmd[3];
                  ready_reg <= 1'b0;
                  busy_reg  <= 1'b1;
                  state_reg <= SETUP;
               end
            end
            SETUP: begin
               if (div_last) begin
                  div_reg   <= '0;
                  sck_reg   <= 1'b1;
                  state_reg <= HIGH;
               end else begin
                  div_reg <= div_reg + DIV_W'(1);
               end
            end
            HIGH: begin
               if (div_last) begin
                  div_reg <= '0;
                  sck_reg <= 1'b0;
                  rx_reg  <= {rx_reg[14:0], miso_synced};
                  if (bit_reg == 4'd15) begin
                     mosi_reg  <= 1'b0;
                     state_reg <= HOLD;
                  end else begin
                     // Next bit goes out on the first LOW cycle, well before the next rise.
                     mosi_reg  <= tx_reg[4'd14 - bit_reg];
                     bit_reg   <= bit_reg + 4'd1;
                     state_reg <= LOW;
                  end
               end else begin
                  div_reg <= div_reg + DIV_W'(1);
               end
            end
            LOW: begin
               if (div_last) begin
                  div_reg   <= '0;
                  sck_reg   <= 1'b1;
                  state_reg <= HIGH;
               end else begin
                  div_reg <= div_reg + DIV_W'(1);
               end
            end
            HOLD: begin
               if (div_last) begin
                  div_reg       <= '0;
                  cs_reg        <= 1'b1;
                  rsp_word_reg  <= rx_reg;
                  rsp_valid_reg <= 1'b1;
                  gap_reg       <= '0;
                  state_reg     <= GAP;
               end else begin
                  div_reg <= div_reg + DIV_W'(1);
               end
            end
            GAP: begin
               // The rsp_valid cycle comes first, then CS_GAP full cycles of cs high.
               if (gap_reg == GAP_LAST) begin
                  ready_reg <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  gap_reg <= gap_reg + GAP_W'(1);
               end
            end
            default: begin
               cs_reg    <= 1'b1;
               sck_reg   <= 1'b0;
               mosi_reg  <= 1'b0;
               ready_reg <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = ready_reg;
   assign busy      = busy_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_word  = rsp_word_reg;
   assign sck       = sck_reg;
   assign cs        = cs_reg;
   assign mosi      = mosi_reg;

endmodule

// File: tb/tb_exi_master.sv
// Directed bench for exi_master: instance 0 uses CLK_DIV=8, instance 1 uses CLK_DIV=16.
`timescale 1ns/1ps
module tb_exi_master;

   logic        clk = 1'b0;
   logic        rst_n     [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic [3:0]  req_cmd   [2];
   logic [7:0]  req_data  [2];
   logic        rsp_valid [2];
   logic [15:0] rsp_word  [2];
   logic        busy      [2];
   logic        sck       [2];
   logic        cs        [2];
   logic        mosi      [2];
   logic        miso      [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exi_master #(.CLK_DIV(8), .CS_GAP(8)) u_div8 (
      .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_cmd(req_cmd[0]), .req_data(req_data[0]), .rsp_valid(rsp_valid[0]),
      .rsp_word(rsp_word[0]), .busy(busy[0]), .sck(sck[0]), .cs(cs[0]),
      .mosi(mosi[0]), .miso(miso[0])
   );

   exi_master #(.CLK_DIV(16), .CS_GAP(8)) u_div16 (
      .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_cmd(req_cmd[1]), .req_data(req_data[1]), .rsp_valid(rsp_valid[1]),
      .rsp_word(rsp_word[1]), .busy(busy[1]), .sck(sck[1]), .cs(cs[1]),
      .mosi(mosi[1]), .miso(miso[1])
   );

   typedef struct {
      int          s;
      logic [3:0]  cmd;
      logic [7:0]  data;
      logic [15:0] pat;
      logic [15:0] exp_mosi;
      logic [15:0] exp_rsp;
      int          glitch_t;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Issues one request and follows the frame cycle by cycle, acting as the responder.
   task automatic run_frame(input int s, input logic [3:0] cmd, input logic [7:0] data,
                            input logic [15:0] pat, input int glitch_t,
                            output logic [15:0] mosi_bits, output logic [15:0] rsp,
                            output int cs_low, output int rsp_at, output int pulses,
                            output int coinc_err, output int timing_err, output int high_cyc);
      int  cd;
      int  nrise;
      int  drive_t;
      bit  prev_sck;
      bit  prev_cs;
      bit  prev_mosi;
      bit  ok;
      cd = (s == 0) ? 8 : 16;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (req_ready[s]) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("ready_before_request", 32'(ok), 32'd1);
      req_valid[s] = 1'b1;
      req_cmd[s]   = cmd;
      req_data[s]  = data;
      @(posedge clk); #1;
      req_valid[s] = 1'b0;
      req_cmd[s]   = ~cmd;
      req_data[s]  = ~data;
      mosi_bits = 16'h0000; rsp = 16'h0000;
      cs_low = 0; rsp_at = -1; pulses = 0; coinc_err = 0; timing_err = 0; high_cyc = 0;
      nrise = 0; drive_t = -1; prev_sck = 1'b0; prev_cs = 1'b1; prev_mosi = mosi[s];
      for (int t = 0; t < 36 * cd + 20; t++) begin
         if (sck[s]) high_cyc++;
         if (!cs[s]) cs_low++;
         if (sck[s] && (mosi[s] !== prev_mosi)) timing_err++;
         if (sck[s] && !prev_sck) begin
            if (nrise < 16) mosi_bits[15 - nrise] = mosi[s];
            if (t != cd * (2 * nrise + 1)) timing_err++;
            nrise++;
            drive_t = t + 3;
         end
         if (t == drive_t && nrise >= 1 && nrise <= 16) miso[s] = pat[16 - nrise];
         if (rsp_valid[s]) begin
            pulses++;
            if (rsp_at < 0) begin
               rsp_at = t;
               rsp    = rsp_word[s];
            end
            if (!(cs[s] && !prev_cs)) coinc_err++;
         end
         if (t == glitch_t) begin
            req_valid[s] = 1'b1;
            req_cmd[s]   = 4'h7;
            req_data[s]  = 8'hFF;
         end else if (t == glitch_t + 1) begin
            req_valid[s] = 1'b0;
         end
         prev_sck  = sck[s];
         prev_cs   = cs[s];
         prev_mosi = mosi[s];
         @(posedge clk); #1;
      end
      check("rise_count", 32'(nrise), 32'd16);
      miso[s] = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] mosi_bits;
      logic [15:0] rsp;
      int cs_low, rsp_at, pulses, coinc_err, timing_err, high_cyc, cd, idle_low;

      vecs[0] = '{0, 4'hB, 8'hA5, 16'h0470, 16'hBA50, 16'h0470, -1};
      vecs[1] = '{0, 4'h2, 8'h3C, 16'hFFFF, 16'h23C0, 16'hFFFF, -1};
      vecs[2] = '{0, 4'h5, 8'h81, 16'h8001, 16'h5810, 16'h8001, -1};
      vecs[3] = '{0, 4'h3, 8'h5A, 16'h1234, 16'h35A0, 16'h1234, 100};
      vecs[4] = '{1, 4'hD, 8'h3C, 16'hC3A5, 16'hD3C0, 16'hC3A5, -1};

      for (int s = 0; s < 2; s++) begin
         rst_n[s] = 1'b0; req_valid[s] = 1'b0; req_cmd[s] = 4'h0;
         req_data[s] = 8'h00; miso[s] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("reset_cs",        32'(cs[0]),        32'd1);
      check("reset_sck",       32'(sck[0]),       32'd0);
      check("reset_mosi",      32'(mosi[0]),      32'd0);
      check("reset_req_ready", 32'(req_ready[0]), 32'd1);
      check("reset_busy",      32'(busy[0]),      32'd0);
      check("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
      check("reset_rsp_word",  32'(rsp_word[0]),  32'd0);
      @(negedge clk);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;
      @(posedge clk); #1;

      // Table-driven frames
      for (int v = 0; v < 5; v++) begin
         cd = (vecs[v].s == 0) ? 8 : 16;
         run_frame(vecs[v].s, vecs[v].cmd, vecs[v].data, vecs[v].pat, vecs[v].glitch_t,
                   mosi_bits, rsp, cs_low, rsp_at, pulses, coinc_err, timing_err, high_cyc);
         $display("frame %0d: div=%0d cmd=%h data=%h mosi=%h rsp=%h rsp_at=%0d cs_low=%0d",
                  v, cd, vecs[v].cmd, vecs[v].data, mosi_bits, rsp, rsp_at, cs_low);
         check("mosi_bits",      32'(mosi_bits),  32'(vecs[v].exp_mosi));
         check("rsp_word",       32'(rsp),        32'(vecs[v].exp_rsp));
         check("cs_low_cycles",  32'(cs_low),     32'(33 * cd));
         check("rsp_valid_time", 32'(rsp_at),     32'(33 * cd));
         check("rsp_pulses",     32'(pulses),     32'd1);
         check("rsp_with_cs_up", 32'(coinc_err),  32'd0);
         check("sck_timing",     32'(timing_err), 32'd0);
         check("sck_high_cycles",32'(high_cyc),   32'(16 * cd));
         check("idle_after",     32'(req_ready[vecs[v].s] && !busy[vecs[v].s]), 32'd1);
         if (vecs[v].glitch_t >= 0) begin
            idle_low = 0;
            for (int i = 0; i < 60; i++) begin
               if (!cs[vecs[v].s]) idle_low++;
               @(posedge clk); #1;
            end
            $display("busy-ignore: cs low cycles after frame=%0d rsp=%h", idle_low, rsp_word[vecs[v].s]);
            check("ignored_request_no_frame", 32'(idle_low), 32'd0);
            check("rsp_word_held", 32'(rsp_word[vecs[v].s]), 32'(vecs[v].exp_rsp));
         end
      end

      // Back-to-back: req_valid held high across two requests
      begin
         int fall_t [2];
         int nf, rise_t, rdy_err, nrise2, npulse, t;
         bit prev_cs, prev_sck;
         logic [15:0] mosi2;
         nf = 0; rise_t = -1; rdy_err = 0; nrise2 = 0; npulse = 0;
         fall_t[0] = -1; fall_t[1] = -1; mosi2 = 16'h0000;
         prev_cs = cs[0]; prev_sck = sck[0];
         req_valid[0] = 1'b1; req_cmd[0] = 4'h9; req_data[0] = 8'h00;
         for (t = 0; t < 800 && npulse < 2; t++) begin
            if (busy[0] && req_ready[0]) rdy_err++;
            if (!cs[0] && prev_cs && nf < 2) begin
               fall_t[nf] = t;
               nf++;
               if (nf == 1) req_cmd[0] = 4'hA;
               else req_valid[0] = 1'b0;
            end
            if (cs[0] && !prev_cs && nf == 1) rise_t = t;
            if (sck[0] && !prev_sck && nf == 2) begin
               if (nrise2 < 16) mosi2[15 - nrise2] = mosi[0];
               nrise2++;
            end
            if (rsp_valid[0]) npulse++;
            prev_cs = cs[0]; prev_sck = sck[0];
            @(posedge clk); #1;
         end
         req_valid[0] = 1'b0;
         $display("back-to-back: falls=%0d,%0d first_rise=%0d mosi2=%h", fall_t[0], fall_t[1], rise_t, mosi2);
         check("b2b_frames",       32'(nf),                   32'd2);
         check("b2b_rsp_pulses",   32'(npulse),               32'd2);
         check("b2b_interval",     32'(fall_t[1] - fall_t[0]), 32'(33 * 8 + 8 + 2));
         check("b2b_cs_gap_ge_8",  32'((fall_t[1] - rise_t) >= 8), 32'd1);
         check("b2b_ready_busy",   32'(rdy_err),              32'd0);
         check("b2b_second_mosi",  32'(mosi2),                32'hA000);
         repeat (20) @(posedge clk);
         #1;
      end

      // Reset in the middle of a frame
      begin
         int nrise, npulse;
         bit prev_sck;
         nrise = 0; prev_sck = 1'b0; npulse = 0;
         req_valid[0] = 1'b1; req_cmd[0] = 4'h6; req_data[0] = 8'h99;
         @(posedge clk); #1;
         req_valid[0] = 1'b0;
         for (int i = 0; i < 400 && nrise < 7; i++) begin
            if (sck[0] && !prev_sck) nrise++;
            prev_sck = sck[0];
            if (nrise < 7) begin
               @(posedge clk); #1;
            end
         end
         check("mid_frame_cs_low", 32'(cs[0]), 32'd0);
         #2;
         rst_n[0] = 1'b0;
         #1;
         $display("reset at bit 6: cs=%0b sck=%0b mosi=%0b ready=%0b", cs[0], sck[0], mosi[0], req_ready[0]);
         check("async_rst_cs",    32'(cs[0]),        32'd1);
         check("async_rst_sck",   32'(sck[0]),       32'd0);
         check("async_rst_mosi",  32'(mosi[0]),      32'd0);
         check("async_rst_ready", 32'(req_ready[0]), 32'd1);
         check("async_rst_busy",  32'(busy[0]),      32'd0);
         repeat (4) begin
            @(posedge clk); #1;
            if (rsp_valid[0]) npulse++;
         end
         @(negedge clk);
         rst_n[0] = 1'b1;
         for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (rsp_valid[0]) npulse++;
         end
         check("rst_no_rsp_valid",   32'(npulse),       32'd0);
         check("rst_release_ready",  32'(req_ready[0]), 32'd1);
         run_frame(0, 4'hE, 8'h42, 16'h5AA5, -1,
                   mosi_bits, rsp, cs_low, rsp_at, pulses, coinc_err, timing_err, high_cyc);
         $display("after reset: mosi=%h rsp=%h rsp_at=%0d", mosi_bits, rsp, rsp_at);
         check("post_rst_mosi",  32'(mosi_bits), 32'hE420);
         check("post_rst_rsp",   32'(rsp),       32'h5AA5);
         check("post_rst_rsp_t", 32'(rsp_at),    32'd264);
         check("post_rst_pulse", 32'(pulses),    32'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
